axi_rd_rr_arbiter: RTL
======================

Name: axi_rd_rr_arbiter

Overview:
Shares one AXI4 read port (AR and R channels) between NUM_MST upstream read requesters, with exactly one burst in flight at a time. Arbitration is round-robin. The block registers the winning AR request, issues it downstream, then steers the R beats back to the granted requester until the RLAST handshake. A beat counter checks the RLAST position against ARLEN, and the RID is checked against ARID; a violation sets a sticky error flag. The block sits between DMA/cache read masters and a single slave or interconnect port.

Parameters:
NUM_MST, 2, number of upstream requesters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
ID_WIDTH, 4, ARID/RID width (passed through unchanged)
LEN_WIDTH, 8, ARLEN width

Ports:
ACLK  in  1  clock
ARESET  in  1  reset, synchronous, active-high
s_araddr  in  NUM_MST*ADDR_WIDTH  per-requester ARADDR, requester i at slice i
s_arlen  in  NUM_MST*LEN_WIDTH  per-requester ARLEN
s_arsize  in  NUM_MST*3  per-requester ARSIZE
s_arburst  in  NUM_MST*2  per-requester ARBURST
s_arid  in  NUM_MST*ID_WIDTH  per-requester ARID
s_arvalid  in  NUM_MST  per-requester ARVALID
s_arready  out  NUM_MST  per-requester ARREADY
s_rdata  out  DATA_WIDTH  RDATA broadcast to all requesters
s_rresp  out  2  RRESP broadcast
s_rlast  out  1  RLAST broadcast
s_rid  out  ID_WIDTH  RID broadcast
s_rvalid  out  NUM_MST  per-requester RVALID, only the granted bit is set
s_rready  in  NUM_MST  per-requester RREADY
m_araddr/m_arlen/m_arsize/m_arburst/m_arid  out  ADDR_WIDTH/LEN_WIDTH/3/2/ID_WIDTH  downstream AR fields, registered
m_arlock/m_arcache/m_arprot/m_arqos  out  1/4/3/4  constants 0 / 4'b0011 / 0 / 0
m_arvalid  out  1  downstream ARVALID
m_arready  in  1  downstream ARREADY
m_rdata/m_rresp/m_rlast/m_rid  in  DATA_WIDTH/2/1/ID_WIDTH  downstream R fields
m_rvalid  in  1  downstream RVALID
m_rready  out  1  downstream RREADY
grant_idx  out  $clog2(NUM_MST)  index of the current owner
busy  out  1  high while state is not IDLE
prot_err  out  1  sticky protocol error flag

Behaviour:
- Reset (ARESET=1 at an ACLK edge):
  - state=IDLE, rr_ptr=0, beat_cnt=0, prot_err=0.
  - All AR registers=0, grant_idx=0.
  - All valid/ready outputs are 0 while ARESET is high.
- Reset mid-burst: the burst is abandoned with no draining. Downstream cleanup is the system's responsibility.
- States: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - Winner = first i with s_arvalid[i]=1, searching from rr_ptr upward with wrap-around modulo NUM_MST.
  - s_arready[winner]=1 combinationally in the same cycle; all other s_arready bits are 0.
  - On handshake: capture the winner's AR fields, set grant_idx=winner, rr_ptr=(winner+1) mod NUM_MST, go to ADDR.
  - No s_arvalid set: stay in IDLE, rr_ptr unchanged.
- ADDR:
  - m_arvalid=1 and the registered AR fields are held stable until m_arready.
  - On m_arvalid&&m_arready: beat_cnt=0, go to DATA.
  - Latency: upstream AR handshake in cycle N gives m_arvalid=1 in cycle N+1 at the earliest.
  - s_arready=0 for all requesters outside IDLE.
- DATA:
  - R forwarding is combinational with zero latency: s_rvalid[grant_idx]=m_rvalid and m_rready=s_rready[grant_idx].
  - s_rdata/s_rresp/s_rlast/s_rid mirror the m_r* inputs.
  - Each R handshake increments beat_cnt (LEN_WIDTH+1 bits, no wrap).
  - On the handshake with m_rlast=1: go to IDLE. The next arbitration is possible in the following cycle, so there are no back-to-back grants in the same cycle.
- Error checks (evaluated on every R handshake; prot_err sets the cycle after and stays set until reset):
  - m_rlast=1 while beat_cnt != m_arlen → prot_err.
  - m_rlast=0 while beat_cnt == m_arlen → prot_err; keep forwarding until RLAST.
  - m_rid != m_arid → prot_err; the beat is still forwarded.
  - Errors never stall or alter the flow.
- Back-pressure:
  - A requester holding s_rready low stalls the downstream R channel.
  - Other requesters are blocked until RLAST.
- Fairness: a requester that is continuously requesting waits at most NUM_MST-1 bursts.
- ARLEN=0 (single beat): DATA exits on the first handshake, and RLAST is required on it.

Test Plan:
- Single request: requester 0, ARADDR=0x1000, ARLEN=3, ID=5; slave returns 4 beats with RLAST on beat 4 → m_araddr=0x1000 one cycle after the AR handshake; s_rvalid=2'b01 for 4 beats; state returns to IDLE; prot_err=0.
- Round-robin: both requesters hold s_arvalid continuously, ARLEN=0 each → grants alternate 0,1,0,1 over 4 bursts; rr_ptr wraps from 1 to 0.
- Back-pressure: during ARLEN=7, s_rready[1] is low for 3 cycles mid-burst → m_rready=0 in those cycles; all 8 beats are delivered in order; requester 0 receives no grant until after RLAST.
- Early RLAST: ARLEN=3 with RLAST on beat 2 → prot_err=1 the next cycle; FSM returns to IDLE; prot_err stays 1 through later clean bursts.
- RID mismatch: ARID=3, slave returns RID=4 → prot_err=1; all beats still forwarded.
- Reset mid-burst: ARESET pulsed during DATA beat 2 → all valids/readies=0 the next cycle, state=IDLE, rr_ptr=0, prot_err=0; a new request is granted normally afterwards.

Source files
------------

// File: rtl/axi_rd_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR + R) between NUM_MST
// requesters, one burst in flight at a time. The winning AR is registered and
// issued downstream. R beats are steered back to the owner until RLAST.
// RLAST position and RID are checked, and any violation latches prot_err.
module axi_rd_rr_arbiter #(
  parameter int NUM_MST    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]   s_araddr,
  input  logic [NUM_MST*LEN_WIDTH-1:0]    s_arlen,
  input  logic [NUM_MST*3-1:0]            s_arsize,
  input  logic [NUM_MST*2-1:0]            s_arburst,
  input  logic [NUM_MST*ID_WIDTH-1:0]     s_arid,
  input  logic [NUM_MST-1:0]              s_arvalid,
  output logic [NUM_MST-1:0]              s_arready,
  output logic [DATA_WIDTH-1:0]           s_rdata,
  output logic [1:0]                      s_rresp,
  output logic                            s_rlast,
  output logic [ID_WIDTH-1:0]             s_rid,
  output logic [NUM_MST-1:0]              s_rvalid,
  input  logic [NUM_MST-1:0]              s_rready,
  output logic [ADDR_WIDTH-1:0]           m_araddr,
  output logic [LEN_WIDTH-1:0]            m_arlen,
  output logic [2:0]                      m_arsize,
  output logic [1:0]                      m_arburst,
  output logic [ID_WIDTH-1:0]             m_arid,
  output logic                            m_arlock,
  output logic [3:0]                      m_arcache,
  output logic [2:0]                      m_arprot,
  output logic [3:0]                      m_arqos,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  input  logic [DATA_WIDTH-1:0]           m_rdata,
  input  logic [1:0]                      m_rresp,
  input  logic                            m_rlast,
  input  logic [ID_WIDTH-1:0]             m_rid,
  input  logic                            m_rvalid,
  output logic                            m_rready,
  output logic [$clog2(NUM_MST)-1:0]      grant_idx,
  output logic                            busy,
  output logic                            prot_err
);

  localparam int IDX_W = $clog2(NUM_MST);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    cand;
  logic                found;
  logic [LEN_WIDTH:0]  beat_cnt;
  logic                r_hs;
  logic                r_err;

  assign m_arlock  = 1'b0;
  assign m_arcache = 4'b0011;
  assign m_arprot  = '0;
  assign m_arqos   = '0;

  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;
  assign s_rid   = m_rid;

  assign busy  = (state != IDLE);
  assign r_hs  = (state == DATA) && m_rvalid && m_rready;
  assign r_err = (m_rlast != (beat_cnt == {1'b0, m_arlen})) || (m_rid != m_arid);

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_MST; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NUM_MST);
      if (!found && s_arvalid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and handshake outputs; everything is held off during reset.
  always_comb begin
    state_nxt = state;
    s_arready = '0;
    s_rvalid  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    if (!ARESET) begin
      case (state)
        IDLE: begin
          if (found) begin
            s_arready[winner] = 1'b1;
            state_nxt         = ADDR;
          end
        end
        ADDR: begin
          m_arvalid = 1'b1;
          if (m_arready) state_nxt = DATA;
        end
        DATA: begin
          s_rvalid[grant_idx] = m_rvalid;
          m_rready            = s_rready[grant_idx];
          if (m_rvalid && s_rready[grant_idx] && m_rlast) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // AR capture, round-robin pointer, beat counter and sticky error flag.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      m_arid    <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      prot_err  <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        m_araddr  <= s_araddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        m_arlen   <= s_arlen[winner*LEN_WIDTH +: LEN_WIDTH];
        m_arsize  <= s_arsize[winner*3 +: 3];
        m_arburst <= s_arburst[winner*2 +: 2];
        m_arid    <= s_arid[winner*ID_WIDTH +: ID_WIDTH];
        grant_idx <= winner;
        rr_ptr    <= (winner == IDX_W'(NUM_MST-1)) ? '0 : winner + 1'b1;
      end
      if (state == ADDR && m_arready) beat_cnt <= '0;
      if (r_hs) begin
        // Saturate rather than wrap when a slave never sends RLAST.
        if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
        if (r_err) prot_err <= 1'b1;
      end
    end
  end

endmodule
